// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and constants for the multicycle signed divider
package div_unit_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Nominal iteration count for the 32-bit MIPS datapath
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER);

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - restoring shift-subtract signed divider (LO=quotient, HI=remainder)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] resultHigh,
  output logic [WIDTH-1:0] resultLow,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  // Iteration counter width follows WIDTH; the package value covers the 32-bit build
  localparam int CNT_W = (WIDTH == DIV_ITER) ? DIV_CNT_W : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_a_neg;
  logic             r_q_neg;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;

  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Unsigned magnitudes; |most-negative| is exact as an unsigned WIDTH-bit value
  assign w_a_mag  = A[WIDTH-1] ? (~A + ONE) : A;
  assign w_b_mag  = B[WIDTH-1] ? (~B + ONE) : B;
  assign w_b_zero = (B == '0);

  // One restoring step: shift {rem,dvd} left, trial-subtract the divisor with a borrow bit
  assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_dvs};
  assign w_borrow    = w_trial[WIDTH];

  // Truncate toward zero: quotient takes the XOR of signs, remainder the dividend sign
  assign w_quo_fix = r_q_neg ? (~r_dvd + ONE) : r_dvd;
  assign w_rem_fix = r_a_neg ? (~r_rem + ONE) : r_rem;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (divOP) begin
          w_next_state = w_b_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX: begin
        w_busy       = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, per-cycle quotient bit, final sign fix-up into HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_a_neg    <= 1'b0;
      r_q_neg    <= 1'b0;
      r_div_zero <= 1'b0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (divOP) begin
            r_dvd      <= w_a_mag;
            r_dvs      <= w_b_mag;
            r_a_neg    <= A[WIDTH-1];
            r_q_neg    <= A[WIDTH-1] ^ B[WIDTH-1];
            r_rem      <= '0;
            r_cnt      <= '0;
            r_div_zero <= w_b_zero;
          end
        end
        S_CALC: begin
          r_rem <= w_borrow ? w_rem_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], ~w_borrow};
          r_cnt <= r_cnt + CNT_ONE;
        end
        S_FIX: begin
          r_res_lo <= w_quo_fix;
          r_res_hi <= w_rem_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign resultHigh = r_res_hi;
  assign resultLow  = r_res_lo;
  assign busy       = w_busy;
  assign done       = w_done;
  assign divZero    = r_div_zero;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit with an expected-result scoreboard
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        divOP = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] resultHigh;
  logic [31:0] resultLow;
  logic        busy;
  logic        done;
  logic        divZero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
    int          busy_cyc;
  } exp_t;

  exp_t sb[$];

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .divOP      (divOP),
    .A          (A),
    .B          (B),
    .resultHigh (resultHigh),
    .resultLow  (resultLow),
    .busy       (busy),
    .done       (done),
    .divZero    (divZero)
  );

  always #5 clk = ~clk;

  // Reference: truncating signed division on magnitudes
  function automatic void div_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
  endfunction

  // Present operands with a one-cycle start pulse; returns #1 after the start edge
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    divOP = 1'b1;
    @(posedge clk);
    #1;
    divOP = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  // Bounded wait for done; lat = negedges after start edge (-1 on timeout)
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    divOP = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (resultHigh !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", resultHigh); end
    checks++; if (resultLow !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", resultLow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL reset_divzero got=%b exp=0", divZero); end
  endtask

  task automatic test_signed();
    logic [31:0] opa [9];
    logic [31:0] opb [9];
    logic [31:0] elo [9];
    logic [31:0] ehi [9];
    int lat;
    int bc;
    exp_t e;
    opa[0] = 32'd100;        opb[0] = 32'd7;          elo[0] = 32'd14;         ehi[0] = 32'd2;
    opa[1] = 32'hFFFFFF9C;   opb[1] = 32'd7;          elo[1] = 32'hFFFFFFF2;   ehi[1] = 32'hFFFFFFFE;
    opa[2] = 32'd100;        opb[2] = 32'hFFFFFFF9;   elo[2] = 32'hFFFFFFF2;   ehi[2] = 32'd2;
    opa[3] = 32'h80000000;   opb[3] = 32'hFFFFFFFF;   elo[3] = 32'h80000000;   ehi[3] = 32'd0;
    opa[4] = 32'd5;          opb[4] = 32'd10;         elo[4] = 32'd0;          ehi[4] = 32'd5;
    for (int i = 5; i < 9; i++) begin
      opa[i] = $urandom;
      opb[i] = (i % 2 == 0) ? $urandom : (($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 1000))
                                                                     : -32'($urandom_range(1, 1000)));
      if (opb[i] == 32'd0) opb[i] = 32'd3;
      div_model(opa[i], opb[i], elo[i], ehi[i]);
    end
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{lo: elo[i], hi: ehi[i], dz: 1'b0, lat: 34, busy_cyc: 33});
      pulse_start(opa[i], opb[i]);
      wait_done(lat, bc);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL signed_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
      checks++; if (bc !== e.busy_cyc) begin errors++; $display("FAIL signed_busy[%0d] got=%0d exp=%0d", i, bc, e.busy_cyc); end
      checks++; if (resultLow !== e.lo) begin errors++; $display("FAIL signed_lo[%0d] %h/%h got=%h exp=%h", i, opa[i], opb[i], resultLow, e.lo); end
      checks++; if (resultHigh !== e.hi) begin errors++; $display("FAIL signed_hi[%0d] %h/%h got=%h exp=%h", i, opa[i], opb[i], resultHigh, e.hi); end
      checks++; if (divZero !== e.dz) begin errors++; $display("FAIL signed_divzero[%0d] got=%b exp=%b", i, divZero, e.dz); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] opa [3] = '{32'd9, 32'd42, 32'd9};
    logic [31:0] opb [3] = '{32'd2, 32'd0, 32'd3};
    int lat;
    int bc;
    exp_t e;
    sb.push_back('{lo: 32'd4, hi: 32'd1, dz: 1'b0, lat: 34, busy_cyc: 33});
    sb.push_back('{lo: 32'd4, hi: 32'd1, dz: 1'b1, lat: 1,  busy_cyc: 0});
    sb.push_back('{lo: 32'd3, hi: 32'd0, dz: 1'b0, lat: 34, busy_cyc: 33});
    for (int i = 0; i < 3; i++) begin
      pulse_start(opa[i], opb[i]);
      wait_done(lat, bc);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL dz_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
      checks++; if (bc !== e.busy_cyc) begin errors++; $display("FAIL dz_busy[%0d] got=%0d exp=%0d", i, bc, e.busy_cyc); end
      checks++; if (resultLow !== e.lo) begin errors++; $display("FAIL dz_lo[%0d] got=%h exp=%h", i, resultLow, e.lo); end
      checks++; if (resultHigh !== e.hi) begin errors++; $display("FAIL dz_hi[%0d] got=%h exp=%h", i, resultHigh, e.hi); end
      checks++; if (divZero !== e.dz) begin errors++; $display("FAIL dz_flag[%0d] got=%b exp=%b", i, divZero, e.dz); end
    end
  endtask

  task automatic test_ignore_busy();
    int lat = -1;
    int extra = 0;
    exp_t e;
    sb.push_back('{lo: 32'd14, hi: 32'd2, dz: 1'b0, lat: 34, busy_cyc: 33});
    pulse_start(32'd100, 32'd7);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (n == 10) begin
        A = 32'd50;
        B = 32'd5;
        divOP = 1'b1;
        @(posedge clk);
        #1;
        divOP = 1'b0;
      end
    end
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (resultLow !== e.lo) begin errors++; $display("FAIL ignore_lo got=%h exp=%h", resultLow, e.lo); end
    checks++; if (resultHigh !== e.hi) begin errors++; $display("FAIL ignore_hi got=%h exp=%h", resultHigh, e.hi); end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int early = 0;
    int lat;
    int bc;
    exp_t e;
    sb.push_back('{lo: 32'd14, hi: 32'd2, dz: 1'b0, lat: 34, busy_cyc: 33});
    pulse_start(32'd100, 32'd7);
    for (int n = 1; n < 15; n++) begin
      @(negedge clk);
      if (done) early++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++; if (resultHigh !== 32'd0) begin errors++; $display("FAIL midreset_hi got=%h exp=0", resultHigh); end
    checks++; if (resultLow !== 32'd0) begin errors++; $display("FAIL midreset_lo got=%h exp=0", resultLow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL midreset_divzero got=%b exp=0", divZero); end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", early); end
    sb.push_back('{lo: 32'd3, hi: 32'd2, dz: 1'b0, lat: 34, busy_cyc: 33});
    pulse_start(32'd20, 32'd6);
    wait_done(lat, bc);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL after_reset_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (resultLow !== e.lo) begin errors++; $display("FAIL after_reset_lo got=%h exp=%h", resultLow, e.lo); end
    checks++; if (resultHigh !== e.hi) begin errors++; $display("FAIL after_reset_hi got=%h exp=%h", resultHigh, e.hi); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    exp_t e;
    sb.push_back('{lo: 32'd3, hi: 32'd1, dz: 1'b0, lat: 34, busy_cyc: 33});
    pulse_start(32'd7, 32'd2);
    wait_done(lat, bc);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (resultLow !== e.lo) begin errors++; $display("FAIL b2b_first_lo got=%h exp=%h", resultLow, e.lo); end
    // Start held across the DONE edge must be ignored there and accepted on the next edge
    A = 32'd1000;
    B = 32'd10;
    divOP = 1'b1;
    @(posedge clk);
    #1;
    A = 32'd77;
    B = 32'd7;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored busy got=%b exp=0", busy); end
    sb.push_back('{lo: 32'd11, hi: 32'd0, dz: 1'b0, lat: 34, busy_cyc: 33});
    @(posedge clk);
    #1;
    divOP = 1'b0;
    wait_done(lat, bc);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (resultLow !== e.lo) begin errors++; $display("FAIL b2b_second_lo got=%h exp=%h", resultLow, e.lo); end
    checks++; if (resultHigh !== e.hi) begin errors++; $display("FAIL b2b_second_hi got=%h exp=%h", resultHigh, e.hi); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
